// File: rtl/mem_wb_pipe_if.sv
// Signal bundle for mem_wb_pipe: execute handshake, data bus, forwarding tap and regfile port.
// master = surrounding core / bus agent, slave = the pipeline stage.
interface mem_wb_pipe_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 32,
  parameter int unsigned RSEL = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_alu_data;
  logic [DW-1:0]   in_reg_data;
  logic            in_mem_rd;
  logic            in_mem_wr;
  logic [1:0]      in_size;
  logic            in_signed;
  logic            in_regs_we;
  logic [RSEL-1:0] in_regs_wsel;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic            d_ack;
  logic [DW-1:0]   d_rdata;
  logic            fwd_valid;
  logic [RSEL-1:0] fwd_wsel;
  logic [DW-1:0]   fwd_data;
  logic            wb_we;
  logic [RSEL-1:0] wb_wsel;
  logic [DW-1:0]   wb_data;
  logic            trap;

  modport master (
    output in_valid, in_alu_data, in_reg_data, in_mem_rd, in_mem_wr, in_size, in_signed,
           in_regs_we, in_regs_wsel, d_ack, d_rdata,
    input  in_ready, d_req, d_we, d_addr, d_wdata, d_be, fwd_valid, fwd_wsel, fwd_data,
           wb_we, wb_wsel, wb_data, trap
  );

  modport slave (
    input  in_valid, in_alu_data, in_reg_data, in_mem_rd, in_mem_wr, in_size, in_signed,
           in_regs_we, in_regs_wsel, d_ack, d_rdata,
    output in_ready, d_req, d_we, d_addr, d_wdata, d_be, fwd_valid, fwd_wsel, fwd_data,
           wb_we, wb_wsel, wb_data, trap
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// Memory + writeback stage: M slot drives a req/ack data bus, W slot drives the regfile port.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned accesses trap instead of being force-aligned.
module mem_wb_pipe #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 32,
  parameter int unsigned RSEL = 4
) (
  input logic          clk,
  input logic          reset,
  mem_wb_pipe_if.slave bus
);
  localparam int unsigned NB = DW / 8;
  localparam int unsigned LB = $clog2(NB);

  typedef enum logic [1:0] {StEmpty, StAlu, StBus} m_state_e;

  m_state_e        r_m_state;
  logic [DW-1:0]   r_m_alu;
  logic [DW-1:0]   r_m_wdata;
  logic [AW-1:0]   r_m_addr;
  logic [NB-1:0]   r_m_be;
  logic [LB-1:0]   r_m_lane;
  logic [1:0]      r_m_size;
  logic            r_m_rd;
  logic            r_m_wr;
  logic            r_m_signed;
  logic            r_m_regs_we;
  logic            r_m_trap;
  logic [RSEL-1:0] r_m_wsel;
  logic            r_wb_we;
  logic [RSEL-1:0] r_wb_wsel;
  logic [DW-1:0]   r_wb_data;
  logic            r_trap;

  logic [1:0]      w_size;
  logic [LB-1:0]   w_lane_raw;
  logic [LB-1:0]   w_lane_mask;
  logic [LB-1:0]   w_lane;
  logic [AW-1:0]   w_addr;
  logic [NB-1:0]   w_be;
  logic [DW-1:0]   w_wdata;
  logic            w_mem;
  logic            w_trap;
  logic            w_req;
  logic            w_m_done;
  logic            w_accept;
  logic [6:0]      w_pad;
  logic [DW-1:0]   w_shift;
  logic [DW-1:0]   w_left;
  logic signed [DW-1:0] w_left_s;
  logic [DW-1:0]   w_sra;
  logic [DW-1:0]   w_load;

  assign w_req    = (r_m_state == StBus);
  assign w_m_done = (r_m_state == StAlu) | (w_req & bus.d_ack);
  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_mem    = bus.in_mem_rd | bus.in_mem_wr;
  assign w_addr   = AW'(bus.in_alu_data);

  // Decode of the incoming op: clamp size, align lane, build byte enables and store lanes.
  always_comb begin
    w_size = bus.in_size;
    if (DW == 32 && w_size == 2'd3) w_size = 2'd2;
    w_lane_raw = bus.in_alu_data[LB-1:0];
    unique case (w_size)
      2'd0:    w_lane_mask = '1;
      2'd1:    w_lane_mask = ~LB'(1);
      2'd2:    w_lane_mask = ~LB'(3);
      default: w_lane_mask = '0;
    endcase
    w_lane = w_lane_raw & w_lane_mask;
`ifdef MEM_MISALIGN_TRAP_EN
    w_trap = w_mem & (|(w_lane_raw & ~w_lane_mask));
`else
    w_trap = 1'b0;
`endif
    unique case (w_size)
      2'd0: begin
        w_be    = NB'(1) << w_lane;
        w_wdata = {NB{bus.in_reg_data[7:0]}};
      end
      2'd1: begin
        w_be    = NB'(3) << w_lane;
        w_wdata = {(DW / 16){bus.in_reg_data[15:0]}};
      end
      2'd2: begin
        w_be    = NB'(4'hF) << w_lane;
        w_wdata = {(DW / 32){bus.in_reg_data[31:0]}};
      end
      default: begin
        w_be    = '1;
        w_wdata = bus.in_reg_data;
      end
    endcase
  end

  // Load extraction: move the lane to bit 0, then shift left/right to zero- or sign-extend.
  always_comb begin
    w_shift = bus.d_rdata >> {r_m_lane, 3'b000};
    unique case (r_m_size)
      2'd0:    w_pad = 7'(DW - 8);
      2'd1:    w_pad = 7'(DW - 16);
      2'd2:    w_pad = 7'(DW - 32);
      default: w_pad = 7'd0;
    endcase
    w_left   = w_shift << w_pad;
    w_left_s = w_left;
    w_sra    = w_left_s >>> w_pad;
    w_load   = r_m_signed ? w_sra : (w_left >> w_pad);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_m_state   <= StEmpty;
      r_m_alu     <= '0;
      r_m_wdata   <= '0;
      r_m_addr    <= '0;
      r_m_be      <= '0;
      r_m_lane    <= '0;
      r_m_size    <= '0;
      r_m_rd      <= 1'b0;
      r_m_wr      <= 1'b0;
      r_m_signed  <= 1'b0;
      r_m_regs_we <= 1'b0;
      r_m_trap    <= 1'b0;
      r_m_wsel    <= '0;
      r_wb_we     <= 1'b0;
      r_wb_wsel   <= '0;
      r_wb_data   <= '0;
      r_trap      <= 1'b0;
    end else begin
      // W reloads every cycle; stores and trapped ops never write a register.
      r_wb_we   <= w_m_done & r_m_regs_we & ~r_m_wr & ~r_m_trap;
      r_wb_wsel <= r_m_wsel;
      r_wb_data <= r_m_rd ? w_load : r_m_alu;
      r_trap    <= w_m_done & r_m_trap;
      if (w_accept) begin
        r_m_state   <= (w_mem & ~w_trap) ? StBus : StAlu;
        r_m_alu     <= bus.in_alu_data;
        r_m_wdata   <= w_wdata;
        r_m_addr    <= w_addr & ~AW'(NB - 1);
        r_m_be      <= w_be;
        r_m_lane    <= w_lane;
        r_m_size    <= w_size;
        r_m_rd      <= bus.in_mem_rd;
        r_m_wr      <= bus.in_mem_wr;
        r_m_signed  <= bus.in_signed;
        r_m_regs_we <= bus.in_regs_we;
        r_m_trap    <= w_trap;
        r_m_wsel    <= bus.in_regs_wsel;
      end else if (w_m_done) begin
        r_m_state <= StEmpty;
      end
    end
  end

  assign bus.in_ready  = (r_m_state == StEmpty) | w_m_done;
  assign bus.d_req     = w_req;
  assign bus.d_we      = w_req & r_m_wr;
  assign bus.d_addr    = r_m_addr;
  assign bus.d_wdata   = r_m_wdata;
  assign bus.d_be      = w_req ? r_m_be : '0;
  assign bus.fwd_valid = (r_m_state != StEmpty) & ~r_m_rd & ~r_m_wr & r_m_regs_we;
  assign bus.fwd_wsel  = r_m_wsel;
  assign bus.fwd_data  = r_m_alu;
  assign bus.wb_we     = r_wb_we;
  assign bus.wb_wsel   = r_wb_wsel;
  assign bus.wb_data   = r_wb_data;
  assign bus.trap      = r_trap;
endmodule
